// File: rtl/drum_voice_mixer.sv
// Polyphonic drum playback: one address counter per voice, ROM data mixed
// into a single saturated offset-binary sample on every sample_tick.
module drum_voice_mixer #(
   parameter int NUM_VOICES  = 5,
   parameter int ADDR_W      = 12,
   parameter int SAMPLE_W    = 8,
   parameter int ROM_LATENCY = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           sample_tick,
   input  logic [NUM_VOICES-1:0]          trig,
   input  logic [NUM_VOICES-1:0]          mute,
   input  logic [NUM_VOICES*ADDR_W-1:0]   voice_len,
   output logic [NUM_VOICES*ADDR_W-1:0]   rom_addr,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] rom_data,
   output logic [NUM_VOICES-1:0]          active,
   output logic [SAMPLE_W-1:0]            mix_out,
   output logic                           mix_valid
);

   localparam int MIX_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
   localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic signed [MIX_W-1:0] MAX_S = MIX_W'(2**(SAMPLE_W-1) - 1);
   localparam logic signed [MIX_W-1:0] MIN_S = MIX_W'(-(2**(SAMPLE_W-1)));

   typedef enum logic {IDLE, PLAY} voice_state_t;

   voice_state_t      r_state    [NUM_VOICES];
   voice_state_t      w_state_nxt[NUM_VOICES];
   logic [ADDR_W-1:0] r_addr     [NUM_VOICES];
   logic [ADDR_W-1:0] w_addr_nxt [NUM_VOICES];
   logic [ADDR_W-1:0] r_len      [NUM_VOICES];
   logic [ADDR_W-1:0] w_len_nxt  [NUM_VOICES];

   logic [ROM_LATENCY-1:0] r_tick_dly;
   logic [NUM_VOICES-1:0]  r_mask_dly [ROM_LATENCY];

   logic signed [SAMPLE_W:0]  w_s;
   logic signed [MIX_W-1:0]   w_sum;
   logic [SAMPLE_W-1:0]       w_mix;

   // NOTE: every comb output gets a default first so no latch is inferred.
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         w_state_nxt[i] = r_state[i];
         w_addr_nxt[i]  = r_addr[i];
         w_len_nxt[i]   = r_len[i];
         case (r_state[i])
            IDLE: begin
               if (trig[i]) begin
                  w_state_nxt[i] = PLAY;
                  w_addr_nxt[i]  = '0;
                  w_len_nxt[i]   = voice_len[i*ADDR_W +: ADDR_W];
               end
            end
            PLAY: begin
               // A trigger outranks a tick landing in the same cycle.
               if (trig[i]) begin
                  w_addr_nxt[i] = '0;
                  w_len_nxt[i]  = voice_len[i*ADDR_W +: ADDR_W];
               end else if (sample_tick) begin
                  if (r_addr[i] == r_len[i]) begin
                     w_state_nxt[i] = IDLE;
                     w_addr_nxt[i]  = '0;
                  end else begin
                     w_addr_nxt[i] = r_addr[i] + 1'b1;
                  end
               end
            end
            default: w_state_nxt[i] = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_state[i] <= IDLE;
            r_addr[i]  <= '0;
            r_len[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_addr[i]  <= w_addr_nxt[i];
            r_len[i]   <= w_len_nxt[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice_out
      assign rom_addr[g*ADDR_W +: ADDR_W] = r_addr[g];
      assign active[g]                    = (r_state[g] == PLAY);
   end

   // Tick and contributing mask travel alongside the ROM read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_dly <= '0;
         for (int k = 0; k < ROM_LATENCY; k++) r_mask_dly[k] <= '0;
      end else begin
         r_tick_dly[0] <= sample_tick;
         r_mask_dly[0] <= active & ~mute;
         for (int k = 1; k < ROM_LATENCY; k++) begin
            r_tick_dly[k] <= r_tick_dly[k-1];
            r_mask_dly[k] <= r_mask_dly[k-1];
         end
      end
   end

   always_comb begin
      w_s   = '0;
      w_sum = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         w_s = $signed({1'b0, rom_data[i*SAMPLE_W +: SAMPLE_W]}) - $signed({1'b0, MID});
         if (r_mask_dly[ROM_LATENCY-1][i])
            w_sum = w_sum + {{(MIX_W-SAMPLE_W-1){w_s[SAMPLE_W]}}, w_s};
      end
      if (w_sum > MAX_S)      w_mix = '1;
      else if (w_sum < MIN_S) w_mix = '0;
      else                    w_mix = w_sum[SAMPLE_W-1:0] + MID;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mix_out   <= MID;
         mix_valid <= 1'b0;
      end else begin
         mix_valid <= r_tick_dly[ROM_LATENCY-1];
         if (r_tick_dly[ROM_LATENCY-1]) mix_out <= w_mix;
      end
   end

endmodule

// File: tb/tb_drum_voice_mixer.sv
// Scoreboard bench for drum_voice_mixer: behavioural voice model predicts
// addresses, activity and each mixed sample, compared when mix_valid fires.
module tb_drum_voice_mixer;

   localparam int N  = 5;
   localparam int AW = 12;
   localparam int SW = 8;
   localparam int L  = 1;

   logic            clk;
   logic            rst_n;
   logic            sample_tick;
   logic [N-1:0]    trig;
   logic [N-1:0]    mute;
   logic [N*AW-1:0] voice_len;
   logic [N*AW-1:0] rom_addr;
   logic [N*SW-1:0] rom_data;
   logic [N-1:0]    active;
   logic [SW-1:0]   mix_out;
   logic            mix_valid;

   drum_voice_mixer #(
      .NUM_VOICES(N), .ADDR_W(AW), .SAMPLE_W(SW), .ROM_LATENCY(L)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .trig(trig),
      .mute(mute), .voice_len(voice_len), .rom_addr(rom_addr),
      .rom_data(rom_data), .active(active), .mix_out(mix_out),
      .mix_valid(mix_valid)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int rom_base [N];
   int rom_step [N];

   function automatic logic [SW-1:0] rom_fn(input int v, input int a);
      return SW'(rom_base[v] + a * rom_step[v]);
   endfunction

   // Single-cycle-latency ROM per voice.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++)
         rom_data[i*SW +: SW] <= rom_fn(i, int'(rom_addr[i*AW +: AW]));
   end

   typedef struct {
      int due;
      int val;
   } exp_t;

   exp_t         q[$];
   logic [N-1:0] m_act;
   int           m_addr [N];
   int           m_len  [N];
   int           cyc;
   int           n_checks;
   int           n_errors;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int model_mix();
      int s = 0;
      for (int i = 0; i < N; i++)
         if (m_act[i] && !mute[i]) s += int'(rom_fn(i, m_addr[i])) - 128;
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      return s + 128;
   endfunction

   task automatic observe();
      bit exp_v;
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      exp_v = (q.size() > 0 && q[0].due == cyc);
      check("mix_valid", int'(mix_valid), int'(exp_v));
      if (exp_v) begin
         check("mix_out", int'(mix_out), q[0].val);
         void'(q.pop_front());
      end
      for (int i = 0; i < N; i++) begin
         check($sformatf("active%0d", i), int'(active[i]), int'(m_act[i]));
         check($sformatf("rom_addr%0d", i), int'(rom_addr[i*AW +: AW]), m_addr[i]);
      end
   endtask

   // Drive one cycle of stimulus, advance the model, then sample after the edge.
   task automatic cycle(input logic [N-1:0] t, input bit tk);
      trig        = t;
      sample_tick = tk;
      if (tk) q.push_back('{due: cyc + L + 1, val: model_mix()});
      for (int i = 0; i < N; i++) begin
         if (t[i]) begin
            m_act[i]  = 1'b1;
            m_addr[i] = 0;
            m_len[i]  = int'(voice_len[i*AW +: AW]);
         end else if (m_act[i] && tk) begin
            if (m_addr[i] == m_len[i]) begin
               m_act[i]  = 1'b0;
               m_addr[i] = 0;
            end else begin
               m_addr[i]++;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      trig        = '0;
      sample_tick = 1'b0;
      observe();
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         cycle('0, 1'b1);
         cycle('0, 1'b0);
      end
   endtask

   task automatic drain();
      int guard = 0;
      while (m_act != '0 && guard < 200) begin
         ticks(1);
         guard++;
      end
      check("drain_done", int'(m_act), 0);
   endtask

   task automatic set_voice(input int v, input int len, input int base, input int step);
      voice_len[v*AW +: AW] = AW'(len);
      rom_base[v] = base;
      rom_step[v] = step;
   endtask

   task automatic model_reset();
      m_act = '0;
      for (int i = 0; i < N; i++) begin
         m_addr[i] = 0;
         m_len[i]  = 0;
      end
      q.delete();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      rst_n       = 1'b0;
      sample_tick = 1'b0;
      trig        = '0;
      mute        = '0;
      voice_len   = '0;
      for (int i = 0; i < N; i++) set_voice(i, 0, 128, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_mix_out", int'(mix_out), 128);
      check("rst_mix_valid", int'(mix_valid), 0);
      check("rst_active", int'(active), 0);
      check("rst_rom_addr", int'(rom_addr == '0), 1);
      rst_n = 1'b1;
      observe();

      // Single voice, len 3, constant 200.
      set_voice(0, 3, 200, 0);
      cycle(5'b00001, 1'b0);
      ticks(5);
      drain();

      // Retrigger voice 2 at address 2.
      set_voice(2, 10, 90, 5);
      cycle(5'b00100, 1'b0);
      ticks(2);
      check("pre_retrig_addr2", int'(rom_addr[2*AW +: AW]), 2);
      cycle(5'b00100, 1'b0);
      check("retrig_addr2", int'(rom_addr[2*AW +: AW]), 0);
      check("retrig_active2", int'(active[2]), 1);
      ticks(12);
      drain();

      // Saturation at both rails.
      for (int i = 0; i < N; i++) set_voice(i, 20, 255, 0);
      cycle('1, 1'b0);
      ticks(2);
      for (int i = 0; i < N; i++) rom_base[i] = 0;
      ticks(2);
      drain();

      // Two voices at 160 sum to 192; muting one leaves 160.
      set_voice(0, 8, 160, 0);
      set_voice(1, 8, 160, 0);
      cycle(5'b00011, 1'b0);
      ticks(2);
      mute = 5'b00010;
      ticks(3);
      mute = '0;
      drain();

      // Ramps on two overlapping voices.
      set_voice(3, 6, 100, 7);
      set_voice(4, 9, 50, 13);
      cycle(5'b01000, 1'b0);
      ticks(2);
      cycle(5'b10000, 1'b0);
      ticks(10);
      drain();

      // Trigger and tick in one cycle; len 0 plays exactly one sample.
      set_voice(1, 4, 90, 0);
      cycle(5'b00010, 1'b1);
      check("same_cycle_addr1", int'(rom_addr[1*AW +: AW]), 0);
      ticks(6);
      set_voice(0, 0, 30, 0);
      cycle(5'b00001, 1'b0);
      ticks(3);
      check("len0_done", int'(active[0]), 0);

      // Reset mid-play with three voices and a mix in flight.
      set_voice(0, 15, 200, 0);
      set_voice(2, 15, 210, 0);
      set_voice(4, 15, 220, 0);
      cycle(5'b10101, 1'b0);
      ticks(2);
      cycle('0, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_active", int'(active), 0);
      check("midrst_rom_addr", int'(rom_addr == '0), 1);
      check("midrst_mix_out", int'(mix_out), 128);
      check("midrst_mix_valid", int'(mix_valid), 0);
      model_reset();
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b1;
      observe();
      ticks(3);

      cycle('0, 1'b0);
      cycle('0, 1'b0);
      check("queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/drum_voice_mixer.md
Name: drum_voice_mixer

Overview:
- Polyphonic successor to the single-voice drum playback path. Gives each of NUM_VOICES drum voices its own address counter, so voices overlap instead of blocking one another.
- Drives one ROM address bus per voice and mixes the returned offset-binary samples into one saturated output sample per sample_tick.
- Sits between the trigger muxing (live debounced buttons / looper playback) and pwm_dac; the per-voice audio ROMs hang off rom_addr/rom_data.

Parameters:
- NUM_VOICES, 5: number of independent voices/ROMs.
- ADDR_W, 12: ROM address width per voice.
- SAMPLE_W, 8: sample width; unsigned offset-binary, midpoint 2^(SAMPLE_W-1) = silence.
- ROM_LATENCY, 1: clock cycles from rom_addr to valid rom_data (>=1).

Ports:
- clk  in  1  system clock (48 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle strobe at the sample rate.
- trig  in  NUM_VOICES  one-cycle start pulse per voice; bit i = voice i.
- mute  in  NUM_VOICES  level; muted voice keeps advancing but contributes 0 to the mix.
- voice_len  in  NUM_VOICES*ADDR_W  last address of each voice's sample; voice i at [i*ADDR_W +: ADDR_W]; sampled on trigger.
- rom_addr  out  NUM_VOICES*ADDR_W  per-voice ROM address, registered.
- rom_data  in  NUM_VOICES*SAMPLE_W  per-voice ROM data, ROM_LATENCY cycles after rom_addr.
- active  out  NUM_VOICES  voice currently playing.
- mix_out  out  SAMPLE_W  mixed sample, offset-binary, registered.
- mix_valid  out  1  one-cycle pulse when mix_out updates.

Behaviour:
- Reset (async assert, sync release): rom_addr=0, active=0, latched lengths=0, tick/active delay lines cleared, mix_out=2^(SAMPLE_W-1) (128), mix_valid=0. Reset mid-playback silences everything immediately.
- Voice FSM, one per voice, states IDLE/PLAY:
  - IDLE + trig[i] -> PLAY; addr=0; len_i <= voice_len slice.
  - PLAY + trig[i] -> retrigger: addr=0, len re-latched, stays PLAY.
  - PLAY + sample_tick + addr!=len -> addr+1.
  - PLAY + sample_tick + addr==len -> IDLE, addr=0.
- trig and sample_tick in the same cycle: trig wins; addr=0; no advance that cycle.
- len=0: voice plays exactly one sample period, then returns to IDLE.
- Voices are fully independent; simultaneous trigs on several bits all start.
- active[i] = (state==PLAY), registered.
- Mix pipeline, with sample_tick high in cycle T:
  - Snapshot the contributing mask = active & ~mute during cycle T.
  - Delay the snapshot and the tick through ROM_LATENCY stages.
  - In cycle T+ROM_LATENCY, rom_data reflects the rom_addr values held in cycle T.
  - Each contributing voice: s_i = rom_data_i - 2^(SAMPLE_W-1), signed SAMPLE_W+1 bits. Non-contributing voices add 0.
  - Sum in signed SAMPLE_W+clog2(NUM_VOICES)+1 bits, no intermediate overflow.
  - Clamp the sum to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], then add 2^(SAMPLE_W-1) back.
  - Register the result into mix_out at the end of cycle T+ROM_LATENCY; mix_valid is high in cycle T+ROM_LATENCY+1 only.
- mix_out holds between ticks. With no contributing voices it goes to exactly 128.
- Ticks closer together than ROM_LATENCY+1 cycles are outside the supported operating range.
- No combinational path from any input to any output.

Test Plan:
- Voice 0, trig then 5 ticks, len=3, ROM constant 200 -> rom_addr0 steps 0,1,2,3,0; active0 high for 4 ticks; mix_out=200 for 4 mixes, then 128.
- Voice 2 retrigger: trig at addr=2 (len=10) -> addr=0 next cycle, active2 stays high, full 11-sample run follows.
- Saturation, N=5: all five voices active with data 255 -> sum +635 -> mix_out=255. All five with data 0 -> -640 -> mix_out=0. Voices 0,1 at data 160 -> mix_out=192.
- Mute: voices 0,1 playing at 160, mute[1]=1 -> mix_out=160; rom_addr1 still advances.
- trig and sample_tick same cycle -> addr=0, no advance. len=0 -> exactly one mix contribution, then active=0.
- rst_n low mid-play with 3 voices active -> same cycle: active=0, rom_addr=0, mix_out=128, mix_valid=0. After release, no output until the next trig.
